// File: rtl/marker_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : marker_defs_pkg
// Brief    : Shared marker protocol definitions (command words, K-flags,
//            error codes, decoder FSM states) for marker simulator/decoder.
// Revision : 1.0 - initial release
// ============================================================================
package marker_defs_pkg;

    localparam logic [7:0]  c_cmd_byte = 8'h1C;
    localparam logic [15:0] c_comma    = 16'hBC3C;

    // Low bytes of command words
    localparam logic [7:0] c_lo_dcs      = 8'h00;
    localparam logic [7:0] c_lo_evt      = 8'h10;
    localparam logic [7:0] c_lo_clk      = 8'h11;
    localparam logic [7:0] c_lo_lpb      = 8'h12;
    localparam logic [7:0] c_lo_diag     = 8'h13;
    localparam logic [7:0] c_lo_tmo      = 8'h14;
    localparam logic [7:0] c_lo_rtx      = 8'h15;
    localparam logic [7:0] c_lo_undef_lo = 8'h20;
    localparam logic [7:0] c_lo_undef_hi = 8'hE9;
    localparam logic [7:0] c_lo_rtx_n    = 8'hEA;
    localparam logic [7:0] c_lo_lpb_n    = 8'hED;
    localparam logic [7:0] c_lo_clk_n    = 8'hEE;
    localparam logic [7:0] c_lo_evt_n    = 8'hEF;

    localparam logic [15:0] c_word_dcs   = {c_cmd_byte, c_lo_dcs};
    localparam logic [15:0] c_word_evt   = {c_cmd_byte, c_lo_evt};
    localparam logic [15:0] c_word_clk   = {c_cmd_byte, c_lo_clk};
    localparam logic [15:0] c_word_lpb   = {c_cmd_byte, c_lo_lpb};
    localparam logic [15:0] c_word_diag  = {c_cmd_byte, c_lo_diag};
    localparam logic [15:0] c_word_tmo   = {c_cmd_byte, c_lo_tmo};
    localparam logic [15:0] c_word_rtx   = {c_cmd_byte, c_lo_rtx};
    localparam logic [15:0] c_word_undef = {c_cmd_byte, c_lo_undef_lo};
    localparam logic [15:0] c_word_rtx_n = {c_cmd_byte, c_lo_rtx_n};
    localparam logic [15:0] c_word_lpb_n = {c_cmd_byte, c_lo_lpb_n};
    localparam logic [15:0] c_word_clk_n = {c_cmd_byte, c_lo_clk_n};
    localparam logic [15:0] c_word_evt_n = {c_cmd_byte, c_lo_evt_n};

    localparam logic [1:0] c_k_data    = 2'b00;
    localparam logic [1:0] c_k_illegal = 2'b01;
    localparam logic [1:0] c_k_cmd     = 2'b10;
    localparam logic [1:0] c_k_comma   = 2'b11;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_MISSING_N = 3'd1,
        ERR_WRONG_N   = 3'd2,
        ERR_ORPHAN_N  = 3'd3,
        ERR_BAD_SEQ   = 3'd4,
        ERR_ILL_CMD   = 3'd5,
        ERR_ILL_K     = 3'd6
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_CLK_N   = 3'd1,
        ST_WAIT_EVT_N   = 3'd2,
        ST_WAIT_RTX_N   = 3'd3,
        ST_WAIT_RTX_SEQ = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        CMD_DCS     = 4'd0,
        CMD_EVT     = 4'd1,
        CMD_CLK     = 4'd2,
        CMD_LPB     = 4'd3,
        CMD_DIAG    = 4'd4,
        CMD_TMO     = 4'd5,
        CMD_RTX     = 4'd6,
        CMD_UNDEF   = 4'd7,
        CMD_RTX_N   = 4'd8,
        CMD_LPB_N   = 4'd9,
        CMD_CLK_N   = 4'd10,
        CMD_EVT_N   = 4'd11,
        CMD_ILLEGAL = 4'd12
    } cmd_e;

    // Classifies the low byte of a word already known to carry the command byte
    function automatic cmd_e classify_cmd(input logic [7:0] lo);
        cmd_e v_cls;
        case (lo)
            c_lo_dcs:   v_cls = CMD_DCS;
            c_lo_evt:   v_cls = CMD_EVT;
            c_lo_clk:   v_cls = CMD_CLK;
            c_lo_lpb:   v_cls = CMD_LPB;
            c_lo_diag:  v_cls = CMD_DIAG;
            c_lo_tmo:   v_cls = CMD_TMO;
            c_lo_rtx:   v_cls = CMD_RTX;
            c_lo_rtx_n: v_cls = CMD_RTX_N;
            c_lo_lpb_n: v_cls = CMD_LPB_N;
            c_lo_clk_n: v_cls = CMD_CLK_N;
            c_lo_evt_n: v_cls = CMD_EVT_N;
            default: begin
                if (lo >= c_lo_undef_lo && lo <= c_lo_undef_hi)
                    v_cls = CMD_UNDEF;
                else
                    v_cls = CMD_ILLEGAL;
            end
        endcase
        return v_cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/marker_decoder_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter; clear has priority over increment.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/marker_decoder.sv
`default_nettype none
// ============================================================================
// Module   : marker_decoder
// Brief    : RX marker stream decoder: strobes, error codes, status counters.
// Revision : 1.0 - initial release
// ============================================================================
module marker_decoder
    import marker_defs_pkg::*;
#(
    parameter logic [7:0]  CMD_BYTE = c_cmd_byte,
    parameter logic [15:0] COMMA    = c_comma,
    parameter int          CNT_W    = 16
) (
    input  logic             RX_CLK,
    input  logic             RX_RESET,
    input  logic [15:0]      DATA_FROM_RX,
    input  logic [1:0]       KCHAR_FROM_RX,
    input  logic             CLR_CNT,
    output logic             CLOCK_MARKER,
    output logic             EVENT_MARKER,
    output logic             LOOPBACK_MARKER,
    output logic             DIAG_MARKER,
    output logic             TIMEOUT_MARKER,
    output logic             RETRANS_REQ,
    output logic [3:0]       RETRANS_SEQ,
    output logic             DCS_REQ,
    output logic             UNDEF_CMD,
    output logic             ERR,
    output logic [2:0]       ERR_CODE,
    output logic [CNT_W-1:0] MARKER_CNT,
    output logic [CNT_W-1:0] ERR_CNT
);

    logic   w_is_cmd;
    logic   w_is_data;
    logic   w_ill_k;
    logic   w_ill_cmd;
    logic   w_seq_ok;
    cmd_e   w_cmd;

    state_e    r_state;
    logic      r_clk_mk, r_evt_mk, r_lpb_mk, r_diag_mk, r_tmo_mk, r_rtx_req;
    logic      r_dcs_req, r_undef, r_err;
    logic [3:0] r_rtx_seq;
    err_code_e r_err_code;

    assign w_cmd     = classify_cmd(DATA_FROM_RX[7:0]);
    assign w_is_data = (KCHAR_FROM_RX == c_k_data);
    assign w_ill_k   = (KCHAR_FROM_RX == c_k_illegal) ||
                       ((KCHAR_FROM_RX == c_k_comma) && (DATA_FROM_RX != COMMA));
    assign w_ill_cmd = (KCHAR_FROM_RX == c_k_cmd) &&
                       ((DATA_FROM_RX[15:8] != CMD_BYTE) || (w_cmd == CMD_ILLEGAL));
    // Legal command only; illegal ones are trapped ahead of the state decode
    assign w_is_cmd  = (KCHAR_FROM_RX == c_k_cmd) && !w_ill_cmd;
    assign w_seq_ok  = (DATA_FROM_RX[15:12] == DATA_FROM_RX[11:8]) &&
                       (DATA_FROM_RX[11:8]  == DATA_FROM_RX[7:4])  &&
                       (DATA_FROM_RX[7:4]   == DATA_FROM_RX[3:0]);

    always_ff @(posedge RX_CLK or posedge RX_RESET) begin
        if (RX_RESET) begin
            r_state    <= ST_IDLE;
            r_clk_mk   <= 1'b0;
            r_evt_mk   <= 1'b0;
            r_lpb_mk   <= 1'b0;
            r_diag_mk  <= 1'b0;
            r_tmo_mk   <= 1'b0;
            r_rtx_req  <= 1'b0;
            r_dcs_req  <= 1'b0;
            r_undef    <= 1'b0;
            r_err      <= 1'b0;
            r_rtx_seq  <= 4'h0;
            r_err_code <= ERR_NONE;
        end else begin
            r_clk_mk  <= 1'b0;
            r_evt_mk  <= 1'b0;
            r_lpb_mk  <= 1'b0;
            r_diag_mk <= 1'b0;
            r_tmo_mk  <= 1'b0;
            r_rtx_req <= 1'b0;
            r_dcs_req <= 1'b0;
            r_undef   <= 1'b0;
            r_err     <= 1'b0;

            if (w_ill_k) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_ILL_K;
                r_state    <= ST_IDLE;
            end else if (w_ill_cmd) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_ILL_CMD;
                r_state    <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_is_cmd) begin
                            case (w_cmd)
                                CMD_CLK:  r_state   <= ST_WAIT_CLK_N;
                                CMD_EVT:  r_state   <= ST_WAIT_EVT_N;
                                CMD_RTX:  r_state   <= ST_WAIT_RTX_N;
                                CMD_LPB:  r_lpb_mk  <= 1'b1;
                                CMD_DIAG: r_diag_mk <= 1'b1;
                                CMD_TMO:  r_tmo_mk  <= 1'b1;
                                CMD_DCS:  r_dcs_req <= 1'b1;
                                CMD_UNDEF: r_undef  <= 1'b1;
                                CMD_RTX_N, CMD_LPB_N, CMD_CLK_N, CMD_EVT_N: begin
                                    r_err      <= 1'b1;
                                    r_err_code <= ERR_ORPHAN_N;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_WAIT_CLK_N, ST_WAIT_EVT_N, ST_WAIT_RTX_N: begin
                        r_state <= ST_IDLE;
                        if (w_is_cmd && (r_state == ST_WAIT_CLK_N) && (w_cmd == CMD_CLK_N)) begin
                            r_clk_mk <= 1'b1;
                        end else if (w_is_cmd && (r_state == ST_WAIT_EVT_N) && (w_cmd == CMD_EVT_N)) begin
                            r_evt_mk <= 1'b1;
                        end else if (w_is_cmd && (r_state == ST_WAIT_RTX_N) && (w_cmd == CMD_RTX_N)) begin
                            r_state <= ST_WAIT_RTX_SEQ;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= w_is_cmd ? ERR_WRONG_N : ERR_MISSING_N;
                        end
                    end
                    ST_WAIT_RTX_SEQ: begin
                        r_state <= ST_IDLE;
                        if (w_is_data && w_seq_ok) begin
                            r_rtx_req <= 1'b1;
                            r_rtx_seq <= DATA_FROM_RX[3:0];
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= w_is_data ? ERR_BAD_SEQ : ERR_MISSING_N;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign CLOCK_MARKER    = r_clk_mk;
    assign EVENT_MARKER    = r_evt_mk;
    assign LOOPBACK_MARKER = r_lpb_mk;
    assign DIAG_MARKER     = r_diag_mk;
    assign TIMEOUT_MARKER  = r_tmo_mk;
    assign RETRANS_REQ     = r_rtx_req;
    assign RETRANS_SEQ     = r_rtx_seq;
    assign DCS_REQ         = r_dcs_req;
    assign UNDEF_CMD       = r_undef;
    assign ERR             = r_err;
    assign ERR_CODE        = r_err_code;

    logic w_marker_inc;
    assign w_marker_inc = r_clk_mk | r_evt_mk | r_lpb_mk | r_diag_mk | r_tmo_mk | r_rtx_req;

    sat_counter #(.CNT_W(CNT_W)) u_marker_cnt (
        .clk     (RX_CLK),
        .rst     (RX_RESET),
        .i_inc   (w_marker_inc),
        .i_clr   (CLR_CNT),
        .o_count (MARKER_CNT)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (RX_CLK),
        .rst     (RX_RESET),
        .i_inc   (r_err),
        .i_clr   (CLR_CNT),
        .o_count (ERR_CNT)
    );

endmodule
`default_nettype wire

// File: tb/tb_marker_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_marker_decoder
// Brief    : Directed self-checking bench for marker_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_marker_decoder;

    localparam logic [8:0] S_NONE  = 9'h000;
    localparam logic [8:0] S_CLK   = 9'h100;
    localparam logic [8:0] S_EVT   = 9'h080;
    localparam logic [8:0] S_LPB   = 9'h040;
    localparam logic [8:0] S_DIAG  = 9'h020;
    localparam logic [8:0] S_TMO   = 9'h010;
    localparam logic [8:0] S_RTX   = 9'h008;
    localparam logic [8:0] S_DCS   = 9'h004;
    localparam logic [8:0] S_UNDEF = 9'h002;
    localparam logic [8:0] S_ERR   = 9'h001;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [1:0]  kch;
    logic        clr;

    logic        clk_mk, evt_mk, lpb_mk, diag_mk, tmo_mk, rtx_req, dcs_req, undef_cmd, err;
    logic [3:0]  rtx_seq;
    logic [2:0]  err_code;
    logic [15:0] mk_cnt, err_cnt;

    logic        s_clk_mk, s_evt_mk, s_lpb_mk, s_diag_mk, s_tmo_mk, s_rtx_req, s_dcs_req, s_undef, s_err;
    logic [3:0]  s_rtx_seq;
    logic [2:0]  s_err_code;
    logic [3:0]  s_mk_cnt, s_err_cnt;

    logic [8:0]  strb;
    assign strb = {clk_mk, evt_mk, lpb_mk, diag_mk, tmo_mk, rtx_req, dcs_req, undef_cmd, err};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    marker_decoder dut (
        .RX_CLK(clk), .RX_RESET(rst), .DATA_FROM_RX(data), .KCHAR_FROM_RX(kch), .CLR_CNT(clr),
        .CLOCK_MARKER(clk_mk), .EVENT_MARKER(evt_mk), .LOOPBACK_MARKER(lpb_mk),
        .DIAG_MARKER(diag_mk), .TIMEOUT_MARKER(tmo_mk), .RETRANS_REQ(rtx_req),
        .RETRANS_SEQ(rtx_seq), .DCS_REQ(dcs_req), .UNDEF_CMD(undef_cmd), .ERR(err),
        .ERR_CODE(err_code), .MARKER_CNT(mk_cnt), .ERR_CNT(err_cnt)
    );

    // Narrow-counter instance on the same stream so saturation is reachable quickly
    marker_decoder #(.CNT_W(4)) dut_sat (
        .RX_CLK(clk), .RX_RESET(rst), .DATA_FROM_RX(data), .KCHAR_FROM_RX(kch), .CLR_CNT(clr),
        .CLOCK_MARKER(s_clk_mk), .EVENT_MARKER(s_evt_mk), .LOOPBACK_MARKER(s_lpb_mk),
        .DIAG_MARKER(s_diag_mk), .TIMEOUT_MARKER(s_tmo_mk), .RETRANS_REQ(s_rtx_req),
        .RETRANS_SEQ(s_rtx_seq), .DCS_REQ(s_dcs_req), .UNDEF_CMD(s_undef), .ERR(s_err),
        .ERR_CODE(s_err_code), .MARKER_CNT(s_mk_cnt), .ERR_CNT(s_err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] k);
        data = d;
        kch  = k;
        @(posedge clk);
        #1;
    endtask

    task automatic comma();
        send(16'hBC3C, 2'b11);
    endtask

    initial begin
        rst  = 1'b1;
        data = 16'hBC3C;
        kch  = 2'b11;
        clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_strobes", {23'd0, strb}, {23'd0, S_NONE});
        check_eq("reset_seq", {28'd0, rtx_seq}, 32'h0);
        check_eq("reset_code", {29'd0, err_code}, 32'h0);
        check_eq("reset_mkcnt", {16'd0, mk_cnt}, 32'h0);
        check_eq("reset_errcnt", {16'd0, err_cnt}, 32'h0);
        rst = 1'b0;

        // Clock marker
        repeat (6) comma();
        check_eq("idle_commas", {23'd0, strb}, {23'd0, S_NONE});
        send(16'h1C11, 2'b10);
        check_eq("clk_first_half", {23'd0, strb}, {23'd0, S_NONE});
        send(16'h1CEE, 2'b10);
        check_eq("clk_marker", {23'd0, strb}, {23'd0, S_CLK});
        comma();
        check_eq("clk_strobe_1cyc", {23'd0, strb}, {23'd0, S_NONE});
        check_eq("clk_mkcnt", {16'd0, mk_cnt}, 32'd1);

        // Retransmission request
        send(16'h1C15, 2'b10);
        send(16'h1CEA, 2'b10);
        check_eq("rtx_mid", {23'd0, strb}, {23'd0, S_NONE});
        send(16'h7777, 2'b00);
        check_eq("rtx_req", {23'd0, strb}, {23'd0, S_RTX});
        check_eq("rtx_seq", {28'd0, rtx_seq}, 32'h7);
        comma();
        check_eq("rtx_mkcnt", {16'd0, mk_cnt}, 32'd2);

        send(16'h1C15, 2'b10);
        send(16'h1CEA, 2'b10);
        send(16'h7077, 2'b00);
        check_eq("badseq_strobes", {23'd0, strb}, {23'd0, S_ERR});
        check_eq("badseq_code", {29'd0, err_code}, 32'd4);
        check_eq("badseq_seq_held", {28'd0, rtx_seq}, 32'h7);
        comma();
        check_eq("badseq_errcnt", {16'd0, err_cnt}, 32'd1);

        clr = 1'b1;
        comma();
        clr = 1'b0;
        check_eq("clr_mkcnt", {16'd0, mk_cnt}, 32'd0);
        check_eq("clr_errcnt", {16'd0, err_cnt}, 32'd0);

        // Complement errors
        send(16'h1C11, 2'b10);
        comma();
        check_eq("missing_n", {23'd0, strb}, {23'd0, S_ERR});
        check_eq("missing_n_code", {29'd0, err_code}, 32'd1);
        send(16'h1C11, 2'b10);
        send(16'h1CEF, 2'b10);
        check_eq("wrong_n", {23'd0, strb}, {23'd0, S_ERR});
        check_eq("wrong_n_code", {29'd0, err_code}, 32'd2);
        send(16'h1CEF, 2'b10);
        check_eq("orphan_n", {23'd0, strb}, {23'd0, S_ERR});
        check_eq("orphan_n_code", {29'd0, err_code}, 32'd3);
        comma();
        check_eq("three_errcnt", {16'd0, err_cnt}, 32'd3);
        check_eq("code_held", {29'd0, err_code}, 32'd3);

        // Event marker, single-word commands, illegal words
        send(16'h1C10, 2'b10);
        send(16'h1C10, 2'b10);
        check_eq("evt_repeat", {23'd0, strb}, {23'd0, S_ERR});
        check_eq("evt_repeat_code", {29'd0, err_code}, 32'd2);
        send(16'h1C10, 2'b10);
        send(16'h1CEF, 2'b10);
        check_eq("evt_marker", {23'd0, strb}, {23'd0, S_EVT});
        send(16'h1C20, 2'b10);
        check_eq("undef_lo", {23'd0, strb}, {23'd0, S_UNDEF});
        send(16'h1CE9, 2'b10);
        check_eq("undef_hi", {23'd0, strb}, {23'd0, S_UNDEF});
        send(16'h1C16, 2'b10);
        check_eq("ill_cmd_1c16", {23'd0, strb}, {23'd0, S_ERR});
        check_eq("ill_cmd_1c16_code", {29'd0, err_code}, 32'd5);
        send(16'h1234, 2'b10);
        check_eq("ill_cmd_byte", {23'd0, strb}, {23'd0, S_ERR});
        check_eq("ill_cmd_byte_code", {29'd0, err_code}, 32'd5);
        send(16'hBC3C, 2'b01);
        check_eq("ill_k01_code", {29'd0, err_code}, 32'd6);
        send(16'h1234, 2'b11);
        check_eq("ill_k11", {23'd0, strb}, {23'd0, S_ERR});
        check_eq("ill_k11_code", {29'd0, err_code}, 32'd6);
        send(16'h1C00, 2'b10);
        check_eq("dcs_req", {23'd0, strb}, {23'd0, S_DCS});
        send(16'h1C12, 2'b10);
        check_eq("loopback", {23'd0, strb}, {23'd0, S_LPB});
        send(16'h1CED, 2'b10);
        check_eq("loopback_orphan", {23'd0, strb}, {23'd0, S_ERR});
        check_eq("loopback_orphan_code", {29'd0, err_code}, 32'd3);
        send(16'h1C13, 2'b10);
        check_eq("diag", {23'd0, strb}, {23'd0, S_DIAG});
        send(16'h1C14, 2'b10);
        check_eq("timeout", {23'd0, strb}, {23'd0, S_TMO});
        send(16'h5555, 2'b00);
        check_eq("idle_data_ignored", {23'd0, strb}, {23'd0, S_NONE});
        send(16'h1C11, 2'b10);
        send(16'h1C16, 2'b10);
        check_eq("ill_cmd_in_wait_code", {29'd0, err_code}, 32'd5);
        comma();
        check_eq("mix_mkcnt", {16'd0, mk_cnt}, 32'd4);
        check_eq("mix_errcnt", {16'd0, err_cnt}, 32'd10);

        // Saturation and clear priority
        clr = 1'b1;
        comma();
        clr = 1'b0;
        check_eq("sat_cleared", {28'd0, s_err_cnt}, 32'h0);
        repeat (16) send(16'hBC3C, 2'b01);
        comma();
        check_eq("sat_errcnt_full", {28'd0, s_err_cnt}, 32'hF);
        check_eq("wide_errcnt_16", {16'd0, err_cnt}, 32'd16);
        send(16'hBC3C, 2'b01);
        comma();
        check_eq("sat_errcnt_hold", {28'd0, s_err_cnt}, 32'hF);
        check_eq("wide_errcnt_17", {16'd0, err_cnt}, 32'd17);
        check_eq("sat_mkcnt", {28'd0, s_mk_cnt}, 32'h0);
        send(16'hBC3C, 2'b01);
        check_eq("err_before_clr", {31'd0, err}, 32'd1);
        clr = 1'b1;
        comma();
        clr = 1'b0;
        check_eq("clr_wins_errcnt", {16'd0, err_cnt}, 32'd0);
        check_eq("clr_wins_sat", {28'd0, s_err_cnt}, 32'h0);

        // Reset mid-sequence
        send(16'h1C15, 2'b10);
        #2 rst = 1'b1;
        #2;
        check_eq("midrst_strobes", {23'd0, strb}, {23'd0, S_NONE});
        check_eq("midrst_seq", {28'd0, rtx_seq}, 32'h0);
        check_eq("midrst_code", {29'd0, err_code}, 32'h0);
        rst = 1'b0;
        send(16'h1CEA, 2'b10);
        check_eq("postrst_orphan", {23'd0, strb}, {23'd0, S_ERR});
        check_eq("postrst_orphan_code", {29'd0, err_code}, 32'd3);
        send(16'h7777, 2'b00);
        check_eq("postrst_no_rtx", {23'd0, strb}, {23'd0, S_NONE});
        check_eq("postrst_errcnt", {16'd0, err_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
